spi_boot_loader: RTL

SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

---
 rtl/spi_boot_pkg.sv | 15 +
 rtl/spi_boot_sync.sv | 48 ++++
 rtl/spi_boot_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_boot_pkg.sv
// Shared types and constants for the SPI boot loader: FSM states and header layout.
package spi_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StDrain
    } boot_state_e;

    localparam int unsigned HDR_BYTES  = 6;
    localparam int unsigned HDR_ADDR_W = 24;

endpackage

// File: rtl/spi_boot_sync.sv
// Two-flop synchronizers for the ARM SPI pins plus sclk-rise and ss edge detectors.
module spi_boot_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm_ss_i,
    input  logic arm_sclk_i,
    input  logic arm_mosi_i,
    output logic ss_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic ss_fall_o,
    output logic ss_rise_o
);

    logic ss_meta_q, ss_q, ss_prev_q;
    logic sclk_meta_q, sclk_q, sclk_prev_q;
    logic mosi_meta_q, mosi_q;

    // Preset to the idle-high bus levels so no edge is seen as reset releases.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ss_meta_q   <= 1'b1;
            ss_q        <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b1;
            sclk_q      <= 1'b1;
            sclk_prev_q <= 1'b1;
            mosi_meta_q <= 1'b1;
            mosi_q      <= 1'b1;
        end else begin
            ss_meta_q   <= arm_ss_i;
            ss_q        <= ss_meta_q;
            ss_prev_q   <= ss_q;
            sclk_meta_q <= arm_sclk_i;
            sclk_q      <= sclk_meta_q;
            sclk_prev_q <= sclk_q;
            mosi_meta_q <= arm_mosi_i;
            mosi_q      <= mosi_meta_q;
        end
    end

    assign ss_o        = ss_q;
    assign mosi_o      = mosi_q;
    assign sclk_rise_o = sclk_q & ~sclk_prev_q;
    assign ss_fall_o   = ~ss_q & ss_prev_q;
    assign ss_rise_o   = ss_q & ~ss_prev_q;

endmodule

// File: rtl/spi_boot_loader.sv
// Receives a 6-byte address header then a data stream over SPI and writes it into SRAM.
module spi_boot_loader
    import spi_boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WE_CYCLES = 3
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              arm_ss,
    input  logic              arm_sclk,
    input  logic              arm_mosi,
    output logic              booting,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic              done
);

    localparam logic [3:0] WE_END   = 4'(WE_CYCLES);
    localparam logic [3:0] CS_END   = 4'(WE_CYCLES + 1);
    localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

    logic ss_s, mosi_s, sclk_rise, ss_fall, ss_rise;

    spi_boot_sync u_sync (
        .clk_i       (clk100),
        .rst_i       (reset),
        .arm_ss_i    (arm_ss),
        .arm_sclk_i  (arm_sclk),
        .arm_mosi_i  (arm_mosi),
        .ss_o        (ss_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise),
        .ss_fall_o   (ss_fall),
        .ss_rise_o   (ss_rise)
    );

    boot_state_e           state_q;
    logic [2:0]            bit_cnt_q, byte_cnt_q;
    logic [7:0]            shift_q;
    logic [HDR_ADDR_W-1:0] start_q, end_q, addr_q;
    logic [3:0]            wcnt_q;
    logic                  stop_pend_q, reached_q;

    logic                  bit_take, byte_done;
    logic [7:0]            byte_val;
    logic [HDR_ADDR_W-1:0] addr_nxt, end_hdr;

    // Shifting continues through WRITE so no bit is lost while the SRAM strobe runs.
    assign bit_take  = sclk_rise && !ss_s && (state_q != StIdle);
    assign byte_done = bit_take && (bit_cnt_q == 3'd7);
    assign byte_val  = {shift_q[6:0], mosi_s};
    assign addr_nxt  = addr_q + HDR_ADDR_W'(1);
    assign end_hdr   = {byte_val, end_q[15:0]};

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            start_q     <= '0;
            end_q       <= '0;
            addr_q      <= '0;
            wcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            reached_q   <= 1'b0;
            booting     <= 1'b0;
            done        <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_cs_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (bit_take) begin
                shift_q   <= byte_val;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        state_q     <= StHdr;
                        bit_cnt_q   <= '0;
                        byte_cnt_q  <= '0;
                        booting     <= 1'b1;
                        reached_q   <= 1'b0;
                        stop_pend_q <= 1'b0;
                    end
                end
                StHdr: begin
                    if (ss_rise) begin
                        state_q   <= StIdle;
                        booting   <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (byte_done) begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        case (byte_cnt_q)
                            3'd0:    start_q[7:0]   <= byte_val;
                            3'd1:    start_q[15:8]  <= byte_val;
                            3'd2:    start_q[23:16] <= byte_val;
                            3'd3:    end_q[7:0]     <= byte_val;
                            3'd4:    end_q[15:8]    <= byte_val;
                            default: end_q[23:16]   <= byte_val;
                        endcase
                        if (byte_cnt_q == HDR_LAST) begin
                            addr_q <= start_q;
                            if (start_q > end_hdr) begin
                                state_q   <= StDrain;
                                reached_q <= 1'b1;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (ss_rise) begin
                        state_q   <= StIdle;
                        booting   <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (byte_done) begin
                        state_q  <= StWrite;
                        ram_data <= byte_val;
                        ram_addr <= addr_q[ADDR_W-1:0];
                        ram_cs_n <= 1'b0;
                        wcnt_q   <= '0;
                    end
                end
                StWrite: begin
                    // A stop request is held until the strobe window has closed.
                    if (ss_rise) stop_pend_q <= 1'b1;
                    wcnt_q <= wcnt_q + 4'd1;
                    if (wcnt_q == 4'd0) ram_we_n <= 1'b0;
                    if (wcnt_q == WE_END) ram_we_n <= 1'b1;
                    if (wcnt_q == CS_END) begin
                        ram_cs_n <= 1'b1;
                        addr_q   <= addr_nxt;
                        if (stop_pend_q || ss_rise) begin
                            state_q     <= StIdle;
                            booting     <= 1'b0;
                            bit_cnt_q   <= '0;
                            stop_pend_q <= 1'b0;
                            done        <= (addr_nxt > end_q);
                        end else if (addr_nxt > end_q) begin
                            state_q   <= StDrain;
                            reached_q <= 1'b1;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StDrain: begin
                    if (ss_rise) begin
                        state_q   <= StIdle;
                        booting   <= 1'b0;
                        bit_cnt_q <= '0;
                        done      <= reached_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
